ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 33 +++
 rtl/ram_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bundle of the per-core request ports and the shared RAM port for ram_arbiter.
// The slave modport is the arbiter's view; the master modport is the cores and RAM side.
interface ram_arbiter_if #(
  parameter int CPUS = 2,
  parameter int AW   = 32
);
  logic [CPUS-1:0]          iREN;
  logic [CPUS-1:0]          dREN;
  logic [CPUS-1:0]          dWEN;
  logic [CPUS-1:0][AW-1:0]  iaddr;
  logic [CPUS-1:0][AW-1:0]  daddr;
  logic [CPUS-1:0][31:0]    dstore;
  logic [CPUS-1:0]          iwait;
  logic [CPUS-1:0]          dwait;
  logic [CPUS-1:0][31:0]    iload;
  logic [CPUS-1:0][31:0]    dload;
  logic                     ramREN;
  logic                     ramWEN;
  logic [AW-1:0]            ramaddr;
  logic [31:0]              ramstore;
  logic [31:0]              ramload;
  logic [1:0]               ramstate;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-core RAM arbiter: four slots (D0, D1, I0, I1), data beats instruction,
// ties inside a class alternate on the core that completed last.
module ram_arbiter #(
  parameter int CPUS = 2,
  parameter int AW   = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  ram_arbiter_if.slave bus,
  output logic         dbg_state_o,
  output logic [1:0]   dbg_grant_o
);
  // Handshake: a slot requests by holding its REN/WEN high; it is served in the
  // single cycle where its wait is 0, and must keep requesting until then.
  typedef enum logic {IDLE, GRANT} state_e;
  typedef enum logic [1:0] {SLOT_D0, SLOT_D1, SLOT_I0, SLOT_I1} slot_e;

  localparam logic [1:0] RS_ACCESS = 2'd2;

  state_e          state_q, state_d;
  slot_e           grant_q, grant_d;
  logic            last_cpu_q, last_cpu_d;
  logic [CPUS-1:0] dreq, ireq, cls_req;
  logic            win_data, win_core;
  logic            g_data, g_core, g_req;

  always_comb begin
    dreq     = bus.dREN | bus.dWEN;
    ireq     = bus.iREN;
    win_data = |dreq;
    cls_req  = win_data ? dreq : ireq;
    win_core = (&cls_req) ? ~last_cpu_q : cls_req[1];
    // grant id encodes class in bit 1 (1 = instruction) and core in bit 0
    g_data   = ~grant_q[1];
    g_core   = grant_q[0];
    g_req    = g_data ? dreq[g_core] : ireq[g_core];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_cpu_d   = last_cpu_q;
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      IDLE: begin
        if ((|dreq) || (|ireq)) begin
          grant_d = slot_e'({~win_data, win_core});
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (g_data) begin
          bus.ramaddr  = bus.daddr[g_core];
          bus.ramstore = bus.dstore[g_core];
          bus.ramWEN   = bus.dWEN[g_core];
          bus.ramREN   = bus.dREN[g_core] & ~bus.dWEN[g_core];
        end else begin
          bus.ramaddr  = bus.iaddr[g_core];
          bus.ramREN   = bus.iREN[g_core];
        end
        if (!g_req) begin
          state_d = IDLE;
        end else if (bus.ramstate == RS_ACCESS) begin
          if (g_data) bus.dwait[g_core] = 1'b0;
          else        bus.iwait[g_core] = 1'b0;
          last_cpu_d = g_core;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int n = 0; n < CPUS; n++) begin
      bus.iload[n] = bus.ramload;
      bus.dload[n] = bus.ramload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      grant_q    <= SLOT_D0;
      last_cpu_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_cpu_q <= last_cpu_d;
    end
  end

  assign dbg_state_o = (state_q == GRANT);
  assign dbg_grant_o = grant_q;
endmodule
